// File: rtl/ctrl_pkg.sv
// Shared definitions for the hardwired control sequencer: opcodes, T-state and
// instruction-class enumerations, and instruction field positions.
package ctrl_pkg;

  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_SHR  = 5'b00101;
  localparam logic [4:0] OP_SHL  = 5'b00111;
  localparam logic [4:0] OP_ROR  = 5'b01000;
  localparam logic [4:0] OP_ROL  = 5'b01001;
  localparam logic [4:0] OP_AND  = 5'b01010;
  localparam logic [4:0] OP_OR   = 5'b01011;
  localparam logic [4:0] OP_MUL  = 5'b01111;
  localparam logic [4:0] OP_DIV  = 5'b10000;
  localparam logic [4:0] OP_NEG  = 5'b10001;
  localparam logic [4:0] OP_NOT  = 5'b10010;
  localparam logic [4:0] OP_NOP  = 5'b11010;
  localparam logic [4:0] OP_HALT = 5'b11011;

  localparam int OPC_LSB = 27;
  localparam int RA_LSB  = 23;
  localparam int RB_LSB  = 19;
  localparam int RC_LSB  = 15;

  typedef enum logic [3:0] {
    ST_IDLE = 4'd0,
    ST_T0   = 4'd1,
    ST_T1   = 4'd2,
    ST_T2   = 4'd3,
    ST_T3   = 4'd4,
    ST_T4   = 4'd5,
    ST_T5   = 4'd6,
    ST_T6   = 4'd7,
    ST_HALT = 4'd8
  } state_e;

  typedef enum logic [2:0] {
    CLS_NOP,
    CLS_TWO,
    CLS_UNARY,
    CLS_HILO,
    CLS_HALT
  } class_e;

  // Unrecognised opcodes fall into CLS_NOP so they execute as nop.
  function automatic class_e decode_class(input logic [4:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_SHR, OP_SHL,
      OP_ROR, OP_ROL, OP_AND, OP_OR:  return CLS_TWO;
      OP_NEG, OP_NOT:                 return CLS_UNARY;
      OP_MUL, OP_DIV:                 return CLS_HILO;
      OP_HALT:                        return CLS_HALT;
      default:                        return CLS_NOP;
    endcase
  endfunction

endpackage

// File: rtl/reg_onehot_decode.sv
// Register index to one-hot select, gated by an enable.
module reg_onehot_decode #(
  parameter int REGS   = 16,
  parameter int RIDX_W = 4
) (
  input  logic              en,
  input  logic [RIDX_W-1:0] idx,
  output logic [REGS-1:0]   onehot
);

  always_comb begin
    onehot = '0;
    for (int i = 0; i < REGS; i++) begin
      onehot[i] = en && (idx == RIDX_W'(i));
    end
  end

endmodule

// File: rtl/control_sequencer.sv
// Hardwired fetch-decode-execute control unit; Moore outputs decode from the
// T-state register and the IR fields fed back from the datapath.
module control_sequencer
  import ctrl_pkg::*;
#(
  parameter int REGS   = 16,
  parameter int RIDX_W = 4
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             run,
  input  logic [31:0]      IR,
  output logic [REGS-1:0]  regIn,
  output logic [REGS-1:0]  regOut,
  output logic             HiIn,
  output logic             LoIn,
  output logic             ZIn,
  output logic             PCIn,
  output logic             MDRIn,
  output logic             YIn,
  output logic             IRIn,
  output logic             MARIn,
  output logic             HiOut,
  output logic             LoOut,
  output logic             ZHiOut,
  output logic             ZLoOut,
  output logic             PCOut,
  output logic             MDROut,
  output logic             MDRread,
  output logic             IncPC,
  output logic [4:0]       ALUcode,
  output logic             halted,
  output logic [3:0]       tstate
);

  state_e state_q, state_d;
  state_e end_state;
  class_e cls;

  logic [4:0]        opcode;
  logic [RIDX_W-1:0] ra, rb, rc;
  logic              ir_unused;

  logic              reg_in_en, reg_out_en;
  logic [RIDX_W-1:0] reg_in_idx, reg_out_idx;

  assign opcode    = IR[OPC_LSB +: 5];
  assign ra        = IR[RA_LSB +: RIDX_W];
  assign rb        = IR[RB_LSB +: RIDX_W];
  assign rc        = IR[RC_LSB +: RIDX_W];
  assign ir_unused = ^IR[RC_LSB-1:0];
  assign cls       = decode_class(opcode);

  // run is only consulted here, so an instruction always runs to completion.
  assign end_state = run ? ST_T0 : ST_IDLE;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: state_d = run ? ST_T0 : ST_IDLE;
      ST_T0:   state_d = ST_T1;
      ST_T1:   state_d = ST_T2;
      ST_T2:   state_d = ST_T3;
      ST_T3: begin
        case (cls)
          CLS_TWO, CLS_UNARY, CLS_HILO: state_d = ST_T4;
          CLS_HALT:                     state_d = ST_HALT;
          default:                      state_d = end_state;
        endcase
      end
      ST_T4:   state_d = (cls == CLS_TWO || cls == CLS_HILO) ? ST_T5 : end_state;
      ST_T5:   state_d = (cls == CLS_HILO) ? ST_T6 : end_state;
      ST_T6:   state_d = end_state;
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!clear) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    HiIn = 1'b0; LoIn = 1'b0; ZIn = 1'b0; PCIn = 1'b0;
    MDRIn = 1'b0; YIn = 1'b0; IRIn = 1'b0; MARIn = 1'b0;
    HiOut = 1'b0; LoOut = 1'b0; ZHiOut = 1'b0; ZLoOut = 1'b0;
    PCOut = 1'b0; MDROut = 1'b0; MDRread = 1'b0; IncPC = 1'b0;
    ALUcode = 5'b00000;
    reg_in_en = 1'b0;  reg_in_idx = ra;
    reg_out_en = 1'b0; reg_out_idx = rb;
    case (state_q)
      ST_T0: begin PCOut = 1'b1; MARIn = 1'b1; IncPC = 1'b1; ZIn = 1'b1; end
      ST_T1: begin ZLoOut = 1'b1; PCIn = 1'b1; MDRread = 1'b1; MDRIn = 1'b1; end
      ST_T2: begin MDROut = 1'b1; IRIn = 1'b1; end
      ST_T3: begin
        case (cls)
          CLS_TWO:   begin reg_out_en = 1'b1; YIn = 1'b1; end
          CLS_UNARY: begin reg_out_en = 1'b1; ZIn = 1'b1; ALUcode = opcode; end
          CLS_HILO:  begin reg_out_en = 1'b1; reg_out_idx = ra; YIn = 1'b1; end
          default: ;
        endcase
      end
      ST_T4: begin
        case (cls)
          CLS_TWO: begin
            reg_out_en = 1'b1; reg_out_idx = rc; ZIn = 1'b1; ALUcode = opcode;
          end
          CLS_UNARY: begin ZLoOut = 1'b1; reg_in_en = 1'b1; end
          CLS_HILO:  begin reg_out_en = 1'b1; ZIn = 1'b1; ALUcode = opcode; end
          default: ;
        endcase
      end
      ST_T5: begin
        case (cls)
          CLS_TWO:  begin ZLoOut = 1'b1; reg_in_en = 1'b1; end
          CLS_HILO: begin ZLoOut = 1'b1; LoIn = 1'b1; end
          default: ;
        endcase
      end
      ST_T6: begin
        if (cls == CLS_HILO) begin ZHiOut = 1'b1; HiIn = 1'b1; end
      end
      default: ;
    endcase
  end

  assign halted = (state_q == ST_HALT);
  assign tstate = state_q;

  reg_onehot_decode #(.REGS(REGS), .RIDX_W(RIDX_W)) u_reg_in_dec (
    .en     (reg_in_en),
    .idx    (reg_in_idx),
    .onehot (regIn)
  );

  reg_onehot_decode #(.REGS(REGS), .RIDX_W(RIDX_W)) u_reg_out_dec (
    .en     (reg_out_en),
    .idx    (reg_out_idx),
    .onehot (regOut)
  );

endmodule

// File: tb/tb_control_sequencer.sv
// Directed table-driven bench for control_sequencer, plus hand sequences for
// reset and the HALT park/exit behaviour.
module tb_control_sequencer;

  localparam logic [3:0] S_IDLE = 4'd0, S_T0 = 4'd1, S_T1 = 4'd2, S_T2 = 4'd3,
                         S_T3 = 4'd4, S_T4 = 4'd5, S_T5 = 4'd6, S_T6 = 4'd7,
                         S_HALT = 4'd8;

  // Strobe vector bit positions: {HiIn,LoIn,ZIn,PCIn,MDRIn,YIn,IRIn,MARIn,
  //  HiOut,LoOut,ZHiOut,ZLoOut,PCOut,MDROut,MDRread,IncPC}
  localparam logic [15:0] B_HIIN = 16'h8000, B_LOIN = 16'h4000, B_ZIN = 16'h2000,
                          B_PCIN = 16'h1000, B_MDRIN = 16'h0800, B_YIN = 16'h0400,
                          B_IRIN = 16'h0200, B_MARIN = 16'h0100, B_ZHIOUT = 16'h0020,
                          B_ZLOOUT = 16'h0010, B_PCOUT = 16'h0008, B_MDROUT = 16'h0004,
                          B_MDRREAD = 16'h0002, B_INCPC = 16'h0001;

  localparam logic [31:0] IR_OR   = 32'h5A1B8000; // or  R4,R3,R7
  localparam logic [31:0] IR_MUL  = 32'h79280000; // mul R2,R5
  localparam logic [31:0] IR_NEG  = 32'h88C80000; // neg R1,R9
  localparam logic [31:0] IR_ADD  = 32'h18918000; // add R1,R2,R3
  localparam logic [31:0] IR_NOP  = 32'hD0000000;
  localparam logic [31:0] IR_UNK  = 32'h08000000; // opcode 00001, undefined
  localparam logic [31:0] IR_HALT = 32'hD8000000;

  logic        clock, clear, run;
  logic [31:0] IR;
  logic [15:0] regIn, regOut;
  logic        HiIn, LoIn, ZIn, PCIn, MDRIn, YIn, IRIn, MARIn;
  logic        HiOut, LoOut, ZHiOut, ZLoOut, PCOut, MDROut, MDRread, IncPC;
  logic [4:0]  ALUcode;
  logic        halted;
  logic [3:0]  tstate;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic        clr;
    logic        rn;
    logic [31:0] ir;
    logic [3:0]  st;
    logic [15:0] ri;
    logic [15:0] ro;
    logic [15:0] sb;
    logic [4:0]  alu;
    logic        h;
  } vec_t;

  vec_t rows[$];

  control_sequencer dut (
    .clock(clock), .clear(clear), .run(run), .IR(IR),
    .regIn(regIn), .regOut(regOut),
    .HiIn(HiIn), .LoIn(LoIn), .ZIn(ZIn), .PCIn(PCIn), .MDRIn(MDRIn),
    .YIn(YIn), .IRIn(IRIn), .MARIn(MARIn),
    .HiOut(HiOut), .LoOut(LoOut), .ZHiOut(ZHiOut), .ZLoOut(ZLoOut),
    .PCOut(PCOut), .MDROut(MDROut), .MDRread(MDRread), .IncPC(IncPC),
    .ALUcode(ALUcode), .halted(halted), .tstate(tstate)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [15:0] act_strb();
    return {HiIn, LoIn, ZIn, PCIn, MDRIn, YIn, IRIn, MARIn,
            HiOut, LoOut, ZHiOut, ZLoOut, PCOut, MDROut, MDRread, IncPC};
  endfunction

  task automatic check(input string name, input int idx,
                       input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s step=%0d got=%0h expected=%0h", name, idx, act, exp);
    end
  endtask

  task automatic check_outputs(input int idx, input logic [3:0] st, input logic [15:0] ri,
                               input logic [15:0] ro, input logic [15:0] sb,
                               input logic [4:0] alu, input logic h);
    int drivers;
    drivers = $countones({HiOut, LoOut, ZHiOut, ZLoOut, PCOut, MDROut}) + ((regOut != 16'h0) ? 1 : 0);
    check("tstate", idx, 32'(tstate), 32'(st));
    check("regIn", idx, 32'(regIn), 32'(ri));
    check("regOut", idx, 32'(regOut), 32'(ro));
    check("strobes", idx, 32'(act_strb()), 32'(sb));
    check("ALUcode", idx, 32'(ALUcode), 32'(alu));
    check("halted", idx, 32'(halted), 32'(h));
    check("bus_excl", idx, 32'((drivers <= 1) && $onehot0(regOut)), 32'd1);
  endtask

  task automatic add_row(input logic clr, input logic rn, input logic [31:0] ir,
                         input logic [3:0] st, input logic [15:0] ri, input logic [15:0] ro,
                         input logic [15:0] sb, input logic [4:0] alu, input logic h);
    vec_t v;
    v.clr = clr; v.rn = rn; v.ir = ir; v.st = st; v.ri = ri; v.ro = ro;
    v.sb = sb; v.alu = alu; v.h = h;
    rows.push_back(v);
  endtask

  task automatic add_fetch(input logic [31:0] ir, input logic rn);
    add_row(1'b1, rn, ir, S_T0, 16'h0, 16'h0, B_PCOUT | B_MARIN | B_INCPC | B_ZIN, 5'd0, 1'b0);
    add_row(1'b1, rn, ir, S_T1, 16'h0, 16'h0, B_ZLOOUT | B_PCIN | B_MDRREAD | B_MDRIN, 5'd0, 1'b0);
    add_row(1'b1, rn, ir, S_T2, 16'h0, 16'h0, B_MDROUT | B_IRIN, 5'd0, 1'b0);
  endtask

  initial begin
    int n;
    clear = 1'b0; run = 1'b1; IR = 32'h0;

    // Each row: inputs driven at negedge, outputs checked, then the rising edge.
    add_row(1'b0, 1'b1, 32'h0, S_IDLE, 16'h0, 16'h0, 16'h0, 5'd0, 1'b0);
    add_row(1'b1, 1'b1, IR_OR, S_IDLE, 16'h0, 16'h0, 16'h0, 5'd0, 1'b0);
    add_fetch(IR_OR, 1'b1);
    add_row(1'b1, 1'b1, IR_OR, S_T3, 16'h0, 16'h0008, B_YIN, 5'd0, 1'b0);
    add_row(1'b1, 1'b1, IR_OR, S_T4, 16'h0, 16'h0080, B_ZIN, 5'b01011, 1'b0);
    add_row(1'b1, 1'b1, IR_OR, S_T5, 16'h0010, 16'h0, B_ZLOOUT, 5'd0, 1'b0);

    add_fetch(IR_MUL, 1'b1);
    add_row(1'b1, 1'b1, IR_MUL, S_T3, 16'h0, 16'h0004, B_YIN, 5'd0, 1'b0);
    add_row(1'b1, 1'b1, IR_MUL, S_T4, 16'h0, 16'h0020, B_ZIN, 5'b01111, 1'b0);
    add_row(1'b1, 1'b1, IR_MUL, S_T5, 16'h0, 16'h0, B_ZLOOUT | B_LOIN, 5'd0, 1'b0);
    add_row(1'b1, 1'b1, IR_MUL, S_T6, 16'h0, 16'h0, B_ZHIOUT | B_HIIN, 5'd0, 1'b0);

    add_fetch(IR_NEG, 1'b1);
    add_row(1'b1, 1'b1, IR_NEG, S_T3, 16'h0, 16'h0200, B_ZIN, 5'b10001, 1'b0);
    add_row(1'b1, 1'b1, IR_NEG, S_T4, 16'h0002, 16'h0, B_ZLOOUT, 5'd0, 1'b0);

    add_fetch(IR_NOP, 1'b1);
    add_row(1'b1, 1'b1, IR_NOP, S_T3, 16'h0, 16'h0, 16'h0, 5'd0, 1'b0);

    // Undefined opcode behaves as nop; run low at its end parks in IDLE.
    add_fetch(IR_UNK, 1'b0);
    add_row(1'b1, 1'b0, IR_UNK, S_T3, 16'h0, 16'h0, 16'h0, 5'd0, 1'b0);
    add_row(1'b1, 1'b1, IR_ADD, S_IDLE, 16'h0, 16'h0, 16'h0, 5'd0, 1'b0);

    // run dropped in T4: add still completes through T5, then IDLE.
    add_fetch(IR_ADD, 1'b1);
    add_row(1'b1, 1'b1, IR_ADD, S_T3, 16'h0, 16'h0004, B_YIN, 5'd0, 1'b0);
    add_row(1'b1, 1'b0, IR_ADD, S_T4, 16'h0, 16'h0008, B_ZIN, 5'b00011, 1'b0);
    add_row(1'b1, 1'b0, IR_ADD, S_T5, 16'h0002, 16'h0, B_ZLOOUT, 5'd0, 1'b0);
    add_row(1'b1, 1'b0, IR_ADD, S_IDLE, 16'h0, 16'h0, 16'h0, 5'd0, 1'b0);
    add_row(1'b1, 1'b1, IR_ADD, S_IDLE, 16'h0, 16'h0, 16'h0, 5'd0, 1'b0);

    // clear in T4 of a second add: IDLE next, no regIn write-back.
    add_fetch(IR_ADD, 1'b1);
    add_row(1'b1, 1'b1, IR_ADD, S_T3, 16'h0, 16'h0004, B_YIN, 5'd0, 1'b0);
    add_row(1'b0, 1'b1, IR_ADD, S_T4, 16'h0, 16'h0008, B_ZIN, 5'b00011, 1'b0);
    add_row(1'b1, 1'b0, IR_ADD, S_IDLE, 16'h0, 16'h0, 16'h0, 5'd0, 1'b0);
    add_row(1'b1, 1'b0, IR_ADD, S_IDLE, 16'h0, 16'h0, 16'h0, 5'd0, 1'b0);

    // Hold clear low for two edges before the table's own reset row.
    repeat (2) @(posedge clock);

    for (int i = 0; i < rows.size(); i++) begin
      @(negedge clock);
      clear = rows[i].clr; run = rows[i].rn; IR = rows[i].ir;
      #1;
      check_outputs(i, rows[i].st, rows[i].ri, rows[i].ro, rows[i].sb, rows[i].alu, rows[i].h);
    end

    // halt: 4 cycles from T0 into HALT, then parked with run held high.
    @(negedge clock);
    clear = 1'b1; run = 1'b1; IR = IR_HALT;
    @(posedge clock); #1;
    check("halt_t0", 100, 32'(tstate), 32'(S_T0));
    n = 0;
    while (tstate !== S_HALT && n < 10) begin
      @(posedge clock); #1;
      n++;
    end
    check("halt_latency", 101, 32'(n), 32'd4);
    for (int k = 0; k < 6; k++) begin
      @(negedge clock);
      check_outputs(110 + k, S_HALT, 16'h0, 16'h0, 16'h0, 5'd0, 1'b1);
    end

    @(negedge clock);
    clear = 1'b0;
    @(negedge clock);
    clear = 1'b1; run = 1'b0;
    #1;
    check_outputs(120, S_IDLE, 16'h0, 16'h0, 16'h0, 5'd0, 1'b0);
    @(negedge clock);
    check_outputs(121, S_IDLE, 16'h0, 16'h0, 16'h0, 5'd0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/control_sequencer.md
# control_sequencer

Hardwired control unit for the phase-1 RISC datapath. It issues every control strobe that the bus-based datapath consumes: the per-register in/out selects, special-register enables, the MDR read, and the ALU operation code. It runs a fetch–decode–execute loop over T-states, decoding the IR contents fed back from the datapath. It sits beside `DataPath` in the top level and replaces hand-driven control.

## Interface
Parameters:
- `REGS`, 16: number of general registers; width of the `regIn`/`regOut` one-hots.
- `RIDX_W`, 4: width of a register field in the instruction.

Ports:
- `clock` in 1: single system clock; all state changes on the rising edge.
- `clear` in 1: synchronous, active-low reset, sampled on the `clock` rising edge.
- `run` in 1: permits the next instruction fetch.
- `IR` in 32: current instruction register contents from the datapath.
- `regIn` out 16: one-hot general-register load enables.
- `regOut` out 16: one-hot general-register bus drives.
- `HiIn`, `LoIn`, `ZIn`, `PCIn`, `MDRIn`, `YIn`, `IRIn`, `MARIn` out 1 each: special-register load enables.
- `HiOut`, `LoOut`, `ZHiOut`, `ZLoOut`, `PCOut`, `MDROut` out 1 each: bus drive enables.
- `MDRread` out 1: MDR input mux selects memory data.
- `IncPC` out 1: ALU computes PC+1 this cycle.
- `ALUcode` out 5: ALU operation select.
- `halted` out 1: sequencer is parked in HALT.
- `tstate` out 4: current state encoding, for debug and bench checking.

## Operation
- Instruction fields: opcode `IR[31:27]`, Ra `IR[26:23]`, Rb `IR[22:19]`, Rc `IR[18:15]`.
- Opcodes: add 00011, sub 00100, shr 00101, shl 00111, ror 01000, rol 01001, and 01010, or 01011, mul 01111, div 10000, neg 10001, not 10010, nop 11010, halt 11011.
- For ALU-class ops, `ALUcode` equals the opcode. Any other opcode executes as nop.
- States:
  - IDLE: reset state. Moves to T0 when `run`=1.
  - T0: `PCOut`, `MARIn`, `IncPC`, `ZIn`.
  - T1: `ZLoOut`, `PCIn`, `MDRread`, `MDRIn`.
  - T2: `MDROut`, `IRIn`.
  - T3 onward depend on the decoded class.
- Two-operand class (add, sub, shifts, rotates, and, or):
  - T3: `regOut[Rb]`, `YIn`.
  - T4: `regOut[Rc]`, `ZIn`, `ALUcode`=opcode.
  - T5: `ZLoOut`, `regIn[Ra]`.
- Unary class (neg, not):
  - T3: `regOut[Rb]`, `ZIn`, `ALUcode`=opcode.
  - T4: `ZLoOut`, `regIn[Ra]`.
- Hi/Lo class (mul, div):
  - T3: `regOut[Ra]`, `YIn`.
  - T4: `regOut[Rb]`, `ZIn`, `ALUcode`.
  - T5: `ZLoOut`, `LoIn`.
  - T6: `ZHiOut`, `HiIn`.
- nop: T3 is empty.
- halt: T3 moves to HALT. HALT drives all strobes 0 and `halted`=1, and is left only by `clear`.
- End of an instruction: after the last T-state, go to T0 if `run`=1, otherwise to IDLE.
- `run` is sampled only at instruction boundaries. Deasserting `run` mid-instruction never truncates the instruction.
- `ALUcode` is 00000 in every state that does not name an ALU op. `IncPC` supersedes `ALUcode` in T0.
- At most one bus driver is active in any state. A bench assertion checks this.

## Timing
- Moore machine: all outputs decode from the state register and the IR fields only. Strobes are valid for the whole cycle; the datapath captures on the next rising edge.
- The IR fields decoded in T3+ are the value loaded at the end of T2.
- Instruction latency, counted from entry to T0:
  - two-operand: 6 cycles
  - unary: 5 cycles
  - mul/div: 7 cycles
  - nop: 4 cycles
  - halt: 4 cycles to HALT
- Back-to-back instructions with `run` held at 1 have no idle cycles between them.
- Reset values: state=IDLE, all strobes 0, `ALUcode`=0, `halted`=0, `tstate`=IDLE encoding.
- `clear`=0 at any edge, including mid-instruction or in HALT, forces IDLE on that edge. `clear` wins over everything else.
- With `run`=1 in IDLE, T0 is entered on the next edge.

## Structure
- Shared package `ctrl_pkg` holds:
  - opcode localparams,
  - the state enumeration (IDLE, T0–T6, HALT),
  - the instruction-class enumeration,
  - field bit positions.
- Sub-module `reg_onehot_decode`: index to `REGS`-wide one-hot with an enable. It is instantiated twice, once for `regIn` and once for `regOut`.
- The top level holds the state register, the next-state logic and the output decode.

## Test plan
- Reset: hold `clear`=0 for 2 cycles with `run`=1 → all outputs 0, `tstate`=IDLE. Release → T0 on the following edge.
- `or R4,R3,R7` (IR=0x5A1B8000) → in order:
  - T3: `regOut`=0x0008, `YIn`.
  - T4: `regOut`=0x0080, `ALUcode`=01011, `ZIn`.
  - T5: `regIn`=0x0010, `ZLoOut`.
  - Then back to T0.
- `mul R2,R5` → T3 drives `regOut`=0x0004, T4 drives 0x0020 with `ALUcode`=01111, T5 asserts `LoIn`, T6 asserts `HiIn`. Total 7 cycles.
- `neg R1,R9` → T3: `regOut`=0x0200, `ZIn`, `ALUcode`=10001. T4: `regIn`=0x0002. Next state T0.
- `halt`, then hold `run`=1 → `halted`=1 indefinitely with all strobes 0. Pulse `clear` → IDLE, `halted`=0.
- Drop `run` during T4 of an add → the instruction completes through T5, then the sequencer goes to IDLE. Assert `clear`=0 during T4 of a second add → IDLE on the next edge with no `regIn` pulse.
